memory_round_checker: RTL
=========================

MEMORY_ROUND_CHECKER -- requirements
Module: memory_round_checker

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 5000, clock cycles allowed per play before timeout (range 2..2^16-1).
REQ-002 Port: clk  input  1  system clock, all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous active-high reset.
REQ-004 Port: iniciar  input  1  start request, level-sampled.
REQ-005 Port: botoes  input  4  player buttons, already synchronised, one bit per colour.
REQ-006 Port: ram_q  input  4  expected play read from the sequence RAM; valid one cycle after ram_addr is sampled.
REQ-007 Port: ram_addr  output  4  registered read address to the sequence RAM.
REQ-008 Port: rodada  output  4  current round index; round r requires plays 0..r.
REQ-009 Port: jogada_ok  output  1  one-cycle pulse per correct play.
REQ-010 Port: pronto  output  1  game finished, level held in terminal states.
REQ-011 Port: acertou  output  1  win flag, held while pronto=1.
REQ-012 Port: errou  output  1  wrong-play flag, held while pronto=1.
REQ-013 Port: timeout  output  1  timeout flag, held while pronto=1.
REQ-014 Port: estado_db  output  4  current FSM state encoding, for debug display.

Function
REQ-015 FSM states: IDLE, PREP, FETCH, WAIT_PLAY, CHECK, NEXT_PLAY, NEXT_ROUND, WIN, LOSE, TOUT.
REQ-016 IDLE: iniciar=1 -> PREP; otherwise stay.
REQ-017 PREP: rodada<=0, ram_addr<=0, timer<=0, all flags cleared; -> FETCH.
REQ-018 FETCH: one wait cycle for RAM read latency; -> WAIT_PLAY; expected value captured from ram_q on exit.
REQ-019 WAIT_PLAY: timer increments each cycle; press event (botoes goes from 0000 to nonzero, edge-detected with a registered copy) -> CHECK with botoes captured; timer reaching TIMEOUT_CYCLES-1 without press -> TOUT.
REQ-020 Press and timeout in same cycle: press wins.
REQ-021 Held buttons do not produce repeat presses; a new press requires botoes=0000 for at least one cycle.
REQ-022 CHECK: captured botoes equal to expected value -> jogada_ok pulse and NEXT_PLAY; any mismatch, including multiple bits set, -> LOSE.
REQ-023 NEXT_PLAY: if ram_addr==rodada -> NEXT_ROUND; else ram_addr<=ram_addr+1, timer<=0, -> FETCH.
REQ-024 NEXT_ROUND: if rodada==15 -> WIN; else rodada<=rodada+1, ram_addr<=0, timer<=0, -> FETCH.
REQ-025 ram_addr and rodada are 4-bit unsigned; increments never wrap, because REQ-023/024 bound them at 15.
REQ-026 WIN/LOSE/TOUT: pronto=1 and exactly one of acertou/errou/timeout=1; rodada and ram_addr frozen; iniciar=1 -> PREP, otherwise stay.
REQ-027 iniciar is ignored in every state except IDLE, WIN, LOSE and TOUT.
REQ-028 Outputs are registered or decoded from state only; no combinational path from botoes or ram_q to any output.
REQ-029 The block never writes the RAM; write control belongs to the RAM owner.

Reset
REQ-030 Asynchronous reset=1 forces IDLE at any time, including mid-round.
REQ-031 Reset values: ram_addr=0, rodada=0, jogada_ok=0, pronto=0, acertou=0, errou=0, timeout=0, timer=0, estado_db=IDLE code, edge register=0000.
REQ-032 After reset release, the FSM leaves IDLE only on iniciar=1.

Verification
REQ-033 RAM preloaded 1,2,4,8,...; iniciar pulse, then press 0001 -> jogada_ok pulse, rodada=1, ram_addr=0; then 0001,0010 -> rodada=2.
REQ-034 Full correct 16-round game -> pronto=1, acertou=1, rodada=15, errou=timeout=0; iniciar then returns the FSM to PREP with all flags cleared.
REQ-035 Round 0 with expected 0010, press 0100 -> LOSE, pronto=1, errou=1; a press of 0011 gives the same result.
REQ-036 TIMEOUT_CYCLES=10, no press after FETCH -> TOUT exactly 10 cycles after entering WAIT_PLAY, timeout=1; a press arriving on the 10th cycle -> CHECK instead.
REQ-037 Button held for 50 cycles -> one jogada_ok pulse only.
REQ-038 reset asserted during WAIT_PLAY in round 5 -> all outputs at reset values, asynchronously before the next clock edge.

Source files
------------

// File: rtl/memory_round_checker_if.sv
// Game-side signal bundle for the memory round checker: player inputs, sequence RAM read port and status outputs.
// The checker takes the slave side; whatever owns the buttons, the RAM and the display takes the master side.
interface memory_round_checker_if;
  logic       iniciar;
  logic [3:0] botoes;
  logic [3:0] ram_q;
  logic [3:0] ram_addr;
  logic [3:0] rodada;
  logic       jogada_ok;
  logic       pronto;
  logic       acertou;
  logic       errou;
  logic       timeout;
  logic [3:0] estado_db;

  modport slave (
    input  iniciar, botoes, ram_q,
    output ram_addr, rodada, jogada_ok, pronto, acertou, errou, timeout, estado_db
  );

  modport master (
    output iniciar, botoes, ram_q,
    input  ram_addr, rodada, jogada_ok, pronto, acertou, errou, timeout, estado_db
  );
endinterface

// File: rtl/memory_round_checker.sv
// Memory-game round checker: replays a stored colour sequence round by round, checks each button press,
// and ends in WIN, LOSE or TOUT. The sequence RAM is only ever read.
module memory_round_checker #(
  parameter int unsigned TIMEOUT_CYCLES = 5000
) (
  input  logic                    clk,
  input  logic                    reset,
  memory_round_checker_if.slave   bus
);

  localparam int unsigned NIB_W   = 4;
  localparam int unsigned TIMER_W = 16;
  localparam logic [NIB_W-1:0]   LAST_IDX   = NIB_W'(15);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    PREP       = 4'd1,
    FETCH      = 4'd2,
    WAIT_PLAY  = 4'd3,
    CHECK      = 4'd4,
    NEXT_PLAY  = 4'd5,
    NEXT_ROUND = 4'd6,
    WIN        = 4'd7,
    LOSE       = 4'd8,
    TOUT       = 4'd9
  } state_t;

  state_t              state_q;
  logic [NIB_W-1:0]    ram_addr_q;
  logic [NIB_W-1:0]    rodada_q;
  logic [NIB_W-1:0]    expected_q;
  logic [NIB_W-1:0]    play_q;
  logic [NIB_W-1:0]    botoes_prev_q;
  logic [TIMER_W-1:0]  timer_q;
  logic                jogada_ok_q;
  logic                pronto_q;
  logic                acertou_q;
  logic                errou_q;
  logic                timeout_q;
  logic                press_c;

  // A press is the first nonzero sample after an all-released sample; holding a button never repeats.
  assign press_c = (botoes_prev_q == '0) && (bus.botoes != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      botoes_prev_q <= '0;
    end else begin
      botoes_prev_q <= bus.botoes;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ram_addr_q  <= '0;
      rodada_q    <= '0;
      expected_q  <= '0;
      play_q      <= '0;
      timer_q     <= '0;
      jogada_ok_q <= 1'b0;
      pronto_q    <= 1'b0;
      acertou_q   <= 1'b0;
      errou_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      jogada_ok_q <= 1'b0;
      unique case (state_q)
        IDLE, WIN, LOSE, TOUT: begin
          // Flags drop on the way into PREP so a restart never shows a stale result.
          if (bus.iniciar) begin
            pronto_q  <= 1'b0;
            acertou_q <= 1'b0;
            errou_q   <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= PREP;
          end
        end
        PREP: begin
          rodada_q   <= '0;
          ram_addr_q <= '0;
          timer_q    <= '0;
          pronto_q   <= 1'b0;
          acertou_q  <= 1'b0;
          errou_q    <= 1'b0;
          timeout_q  <= 1'b0;
          state_q    <= FETCH;
        end
        FETCH: begin
          expected_q <= bus.ram_q;
          state_q    <= WAIT_PLAY;
        end
        WAIT_PLAY: begin
          timer_q <= timer_q + TIMER_W'(1);
          if (press_c) begin
            play_q  <= bus.botoes;
            state_q <= CHECK;
          end else if (timer_q == TIMER_LAST) begin
            pronto_q  <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= TOUT;
          end
        end
        CHECK: begin
          // Exact match only: extra bits set count as a wrong colour.
          if (play_q == expected_q) begin
            jogada_ok_q <= 1'b1;
            state_q     <= NEXT_PLAY;
          end else begin
            pronto_q <= 1'b1;
            errou_q  <= 1'b1;
            state_q  <= LOSE;
          end
        end
        NEXT_PLAY: begin
          if (ram_addr_q == rodada_q) begin
            state_q <= NEXT_ROUND;
          end else begin
            ram_addr_q <= ram_addr_q + NIB_W'(1);
            timer_q    <= '0;
            state_q    <= FETCH;
          end
        end
        NEXT_ROUND: begin
          if (rodada_q == LAST_IDX) begin
            pronto_q  <= 1'b1;
            acertou_q <= 1'b1;
            state_q   <= WIN;
          end else begin
            rodada_q   <= rodada_q + NIB_W'(1);
            ram_addr_q <= '0;
            timer_q    <= '0;
            state_q    <= FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.rodada    = rodada_q;
  assign bus.jogada_ok = jogada_ok_q;
  assign bus.pronto    = pronto_q;
  assign bus.acertou   = acertou_q;
  assign bus.errou     = errou_q;
  assign bus.timeout   = timeout_q;
  assign bus.estado_db = 4'(state_q);

endmodule
